serial_gate_deserializer: RTL and testbench
===========================================

// Module: serial_gate_deserializer
//
// PURPOSE
// Downstream stage for the single-bit mux-built gates. Accepts a serial stream
// of operand bit pairs (a, b) over a valid/ready handshake. Applies a selectable
// 2-input gate, realised as 2:1 mux selections, to each pair. Packs the result
// bits LSB-first into a WIDTH-bit word, then presents the word downstream over a
// second valid/ready handshake. Words can end early via up_last.
//
// PARAMETERS
// WIDTH    8   result bits per full word; legal range 2..32
// LEN_W    $clog2(WIDTH+1)   width of down_len; derived, do not override
//
// PORTS
// clk         in   1       single clock; all logic on posedge
// rst_n       in   1       synchronous reset, active-low
// up_valid    in   1       operand pair valid
// up_ready    out  1       stage can accept a pair
// up_a        in   1       operand a
// up_b        in   1       operand b
// up_op       in   2       gate select: 00 AND, 01 OR, 10 XOR, 11 NAND
// up_last     in   1       this pair closes the current word
// down_valid  out  1       result word valid
// down_ready  in   1       consumer accepts word
// down_data   out  WIDTH   packed results; bit i = i-th accepted pair
// down_len    out  LEN_W   number of valid bits in down_data, 1..WIDTH
//
// BEHAVIOUR
// - Reset (rst_n=0 at posedge): state=COLLECT, cnt=0, op_q=00, down_data=0,
//   down_len=0, down_valid=0. up_ready=1 from the first cycle after reset.
// - Gate function (mux form):
//   - AND  = a ? b  : 0
//   - OR   = a ? 1  : b
//   - XOR  = a ? ~b : b
//   - NAND = a ? ~b : 1
// - Beat accepted = up_valid & up_ready at posedge.
// - FSM COLLECT: up_ready=1, down_valid=0.
//   - Accepted beat with cnt==0: latch up_op into op_q and use it for this beat.
//     up_op on later beats of the same word is ignored.
//   - Each accepted beat writes gate(a,b) to down_data[cnt] and increments cnt.
//   - If cnt==WIDTH-1 or up_last=1, go to OUTPUT and set down_len=cnt+1.
// - FSM OUTPUT: up_ready=0, down_valid=1.
//   - down_data and down_len stay stable until the handshake.
//   - On down_ready=1: return to COLLECT, clear down_data, cnt and down_len.
//   - up_ready rises the cycle after the handshake.
// - Unwritten bits of a short word (index >= down_len) read 0.
// - Registered outputs only. No combinational path down_ready->up_ready or
//   up_valid->down_valid.
// - Latency: last accepted beat -> down_valid=1 on the next cycle.
// - Max throughput: one word per WIDTH+1 cycles.
// - up_last on the beat where cnt==WIDTH-1: a single WIDTH-long word, no extra
//   empty word.
// - up_valid=0 gaps mid-word: cnt holds, no timeout.
// - up_valid during OUTPUT: not accepted; upstream must hold its beat.
// - Reset mid-word or mid-OUTPUT: partial or pending word is discarded;
//   down_valid=0 the next cycle.
//
// TESTING
// - WIDTH=8, op=AND, 8 back-to-back beats a=1, b=10110011 (LSB first) ->
//   down_data=8'hCD, down_len=8, down_valid 1 cycle after beat 8.
// - op=XOR, 3 beats (1,0),(1,1),(0,1) with up_last on beat 3 ->
//   down_data=8'h05, down_len=3.
// - Hold down_ready=0 for 5 cycles in OUTPUT -> data stable, up_ready=0
//   throughout. Word accepted on cycle 6; up_ready=1 on cycle 7.
// - Change up_op from OR to NAND at beat 4 of a word, all a=0,b=0 ->
//   all bits use OR, down_data=8'h00. The next word uses NAND -> 8'hFF.
// - Assert rst_n=0 after 5 beats -> down_valid=0, cnt=0.
//   A fresh 8-beat word then completes normally.
// - Random gaps on up_valid and random down_ready vs. a reference model ->
//   no lost, duplicated or reordered bits.

Source files
------------

// File: rtl/serial_gate_deserializer.sv
// serial_gate_deserializer
// Accepts serial (a, b) operand pairs, applies a 2:1-mux-built gate to each pair
// and packs the result bits LSB-first into a WIDTH-bit word. A word closes when
// WIDTH bits are collected or the upstream flags up_last, and is then offered
// downstream until taken. One word is held at a time: collection stalls
// (up_ready=0) while a finished word waits for down_ready.
module serial_gate_deserializer #(
  parameter int WIDTH = 8,
  parameter int LEN_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic             up_a,
  input  logic             up_b,
  input  logic [1:0]       up_op,
  input  logic             up_last,
  output logic             down_valid,
  input  logic             down_ready,
  output logic [WIDTH-1:0] down_data,
  output logic [LEN_W-1:0] down_len
);

  typedef enum logic {
    COLLECT = 1'b0,
    OUTPUT  = 1'b1
  } state_t;

  localparam logic [LEN_W-1:0] LAST_IDX = LEN_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [LEN_W-1:0] cnt;
  logic [1:0]       op_q;
  logic [1:0]       op_eff;
  logic             accept;
  logic             word_done;
  logic             bit_res;
  logic [WIDTH-1:0] data_nxt;

  // Gate realised purely as 2:1 selections steered by operand a.
  function automatic logic gate_bit(input logic [1:0] op, input logic a, input logic b);
    logic r;
    case (op)
      2'b00:   r = a ? b    : 1'b0;  // AND
      2'b01:   r = a ? 1'b1 : b;     // OR
      2'b10:   r = a ? ~b   : b;     // XOR
      default: r = a ? ~b   : 1'b1;  // NAND
    endcase
    return r;
  endfunction

  // The opcode is taken live on the first beat of a word, then frozen in op_q.
  assign op_eff    = (cnt == '0) ? up_op : op_q;
  assign accept    = up_valid & up_ready;
  assign word_done = accept & (up_last | (cnt == LAST_IDX));
  assign bit_res   = gate_bit(op_eff, up_a, up_b);

  // Merge the new result bit into the word at position cnt.
  always_comb begin
    data_nxt = down_data;
    for (int i = 0; i < WIDTH; i++) begin
      if (cnt == LEN_W'(i)) data_nxt[i] = bit_res;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= COLLECT;
    else        state <= state_nxt;
  end

  // Next-state logic; handshake outputs decode the registered state only.
  always_comb begin
    state_nxt  = state;
    up_ready   = 1'b0;
    down_valid = 1'b0;
    case (state)
      COLLECT: begin
        up_ready = 1'b1;
        if (word_done) state_nxt = OUTPUT;
      end
      OUTPUT: begin
        down_valid = 1'b1;
        if (down_ready) state_nxt = COLLECT;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  // Word assembly: count, opcode latch, packed data and final length.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      op_q      <= 2'b00;
      down_data <= '0;
      down_len  <= '0;
    end else if (accept) begin
      if (cnt == '0) op_q <= up_op;
      down_data <= data_nxt;
      cnt       <= cnt + LEN_W'(1);
      if (word_done) down_len <= cnt + LEN_W'(1);
    end else if (down_valid && down_ready) begin
      cnt       <= '0;
      down_data <= '0;
      down_len  <= '0;
    end
  end

endmodule

// File: tb/tb_serial_gate_deserializer.sv
// Testbench for serial_gate_deserializer: directed scenarios plus a randomized
// run scored against a word-level reference model.
module tb_serial_gate_deserializer;

  localparam int W = 8;
  localparam logic [1:0] OP_AND = 2'b00, OP_OR = 2'b01, OP_XOR = 2'b10, OP_NAND = 2'b11;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         up_valid;
  logic         up_ready;
  logic         up_a;
  logic         up_b;
  logic [1:0]   up_op;
  logic         up_last;
  logic         down_valid;
  logic         down_ready;
  logic [W-1:0] down_data;
  logic [3:0]   down_len;

  int checks = 0;
  int errors = 0;

  serial_gate_deserializer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .up_valid(up_valid), .up_ready(up_ready),
    .up_a(up_a), .up_b(up_b), .up_op(up_op), .up_last(up_last),
    .down_valid(down_valid), .down_ready(down_ready),
    .down_data(down_data), .down_len(down_len)
  );

  always #5 clk = ~clk;

  // Reference gate from its boolean definition.
  function automatic logic ref_gate(input logic [1:0] op, input logic a, input logic b);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Present one beat and hold it until the DUT takes it.
  task automatic send_beat(input logic a, input logic b, input logic [1:0] op, input logic last);
    int n = 0;
    up_valid = 1'b1; up_a = a; up_b = b; up_op = op; up_last = last;
    while (!up_ready && n < 200) begin step(); n++; end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL send_timeout up_ready stayed %0b, required 1", up_ready);
    end
    step();
    up_valid = 1'b0; up_last = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; step(); rst_n = 1'b1;
  endtask

  task automatic take_word();
    down_ready = 1'b1; step(); down_ready = 1'b0;
  endtask

  task automatic test_reset();
    up_valid = 0; up_a = 0; up_b = 0; up_op = 0; up_last = 0; down_ready = 0;
    rst_n = 1'b0; step(); step(); rst_n = 1'b1;
    checks++;
    if (down_valid !== 1'b0 || down_data !== '0 || down_len !== 4'd0) begin
      errors++;
      $display("FAIL reset_outputs got v=%0b d=%h l=%0d, required v=0 d=00 l=0", down_valid, down_data, down_len);
    end
    checks++;
    if (up_ready !== 1'b1) begin
      errors++; $display("FAIL reset_up_ready got %0b, required 1", up_ready);
    end
  endtask

  // AND full word, then hold-off for 5 cycles and release.
  task automatic test_full_and_hold();
    logic [W-1:0] b = 8'b1100_1101;
    logic [W-1:0] seen;
    logic [3:0]   seen_len;
    for (int i = 0; i < W; i++) send_beat(1'b1, b[i], OP_AND, 1'b0);
    checks++;
    if (down_valid !== 1'b1 || down_data !== 8'hCD || down_len !== 4'd8) begin
      errors++;
      $display("FAIL and_full got v=%0b d=%h l=%0d, required v=1 d=cd l=8", down_valid, down_data, down_len);
    end
    seen = down_data; seen_len = down_len;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (down_valid !== 1'b1 || up_ready !== 1'b0 || down_data !== seen || down_len !== seen_len) begin
        errors++;
        $display("FAIL hold_cycle%0d got v=%0b r=%0b d=%h l=%0d, required v=1 r=0 d=%h l=%0d",
                 c, down_valid, up_ready, down_data, down_len, seen, seen_len);
      end
    end
    take_word();
    checks++;
    if (down_valid !== 1'b0 || up_ready !== 1'b1 || down_data !== '0 || down_len !== 4'd0) begin
      errors++;
      $display("FAIL after_take got v=%0b r=%0b d=%h l=%0d, required v=0 r=1 d=00 l=0",
               down_valid, up_ready, down_data, down_len);
    end
  endtask

  task automatic test_xor_short();
    send_beat(1'b1, 1'b0, OP_XOR, 1'b0);
    send_beat(1'b1, 1'b1, OP_XOR, 1'b0);
    send_beat(1'b0, 1'b1, OP_XOR, 1'b1);
    checks++;
    if (down_valid !== 1'b1 || down_data !== 8'h05 || down_len !== 4'd3) begin
      errors++;
      $display("FAIL xor_short got v=%0b d=%h l=%0d, required v=1 d=05 l=3", down_valid, down_data, down_len);
    end
    take_word();
  endtask

  task automatic test_op_latch();
    for (int i = 0; i < W; i++) send_beat(1'b0, 1'b0, (i < 3) ? OP_OR : OP_NAND, 1'b0);
    checks++;
    if (down_data !== 8'h00 || down_len !== 4'd8) begin
      errors++; $display("FAIL op_latch_or got d=%h l=%0d, required d=00 l=8", down_data, down_len);
    end
    take_word();
    for (int i = 0; i < W; i++) send_beat(1'b0, 1'b0, OP_NAND, 1'b0);
    checks++;
    if (down_data !== 8'hFF || down_len !== 4'd8) begin
      errors++; $display("FAIL op_latch_nand got d=%h l=%0d, required d=ff l=8", down_data, down_len);
    end
    take_word();
  endtask

  // up_last on the WIDTH-th beat must not yield an extra empty word.
  task automatic test_last_at_full();
    logic [W-1:0] b = W'($urandom);
    for (int i = 0; i < W; i++) send_beat(1'b1, b[i], OP_AND, i == W - 1);
    checks++;
    if (down_data !== b || down_len !== 4'd8) begin
      errors++; $display("FAIL last_full got d=%h l=%0d, required d=%h l=8", down_data, down_len, b);
    end
    take_word();
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (down_valid !== 1'b0) begin
        errors++; $display("FAIL no_empty_word cycle%0d got v=%0b, required 0", c, down_valid);
      end
      step();
    end
  endtask

  task automatic test_mid_reset();
    logic [W-1:0] b = W'($urandom);
    for (int i = 0; i < 5; i++) send_beat(1'b1, 1'b1, OP_OR, 1'b0);
    do_reset();
    checks++;
    if (down_valid !== 1'b0 || up_ready !== 1'b1 || down_data !== '0) begin
      errors++;
      $display("FAIL reset_midword got v=%0b r=%0b d=%h, required v=0 r=1 d=00", down_valid, up_ready, down_data);
    end
    for (int i = 0; i < W; i++) send_beat(1'b1, b[i], OP_AND, 1'b0);
    checks++;
    if (down_valid !== 1'b1 || down_data !== b || down_len !== 4'd8) begin
      errors++;
      $display("FAIL fresh_word got v=%0b d=%h l=%0d, required v=1 d=%h l=8", down_valid, down_data, down_len, b);
    end
    do_reset();
    checks++;
    if (down_valid !== 1'b0 || down_data !== '0 || down_len !== 4'd0) begin
      errors++;
      $display("FAIL reset_output got v=%0b d=%h l=%0d, required v=0 d=00 l=0", down_valid, down_data, down_len);
    end
  endtask

  task automatic test_random();
    localparam int N = 300;
    logic         ra [N];
    logic         rb [N];
    logic [1:0]   rop[N];
    logic         rl [N];
    logic [W-1:0] exp_d[$];
    logic [3:0]   exp_l[$];
    logic [W-1:0] acc = '0;
    logic [1:0]   cur_op = '0;
    int           cnt = 0;
    int           nexp;
    int           got = 0;
    for (int i = 0; i < N; i++) begin
      ra[i] = 1'($urandom); rb[i] = 1'($urandom); rop[i] = 2'($urandom);
      rl[i] = ($urandom_range(0, 5) == 0) || (i == N - 1);
      if (cnt == 0) cur_op = rop[i];
      acc[cnt] = ref_gate(cur_op, ra[i], rb[i]);
      cnt++;
      if (rl[i] || cnt == W) begin
        exp_d.push_back(acc); exp_l.push_back(4'(cnt));
        acc = '0; cnt = 0;
      end
    end
    nexp = exp_d.size();
    fork
      begin
        for (int i = 0; i < N; i++) begin
          int g = $urandom_range(0, 2);
          for (int k = 0; k < g; k++) step();
          send_beat(ra[i], rb[i], rop[i], rl[i]);
        end
      end
      begin
        int cyc = 0;
        while (got < nexp && cyc < 20000) begin
          logic         rdy = 1'($urandom);
          logic         v = down_valid;
          logic [W-1:0] d = down_data;
          logic [3:0]   l = down_len;
          down_ready = rdy;
          if (down_valid && up_ready) begin
            checks++; errors++;
            $display("FAIL both_ready got v=1 r=1, required not both");
          end
          step();
          cyc++;
          if (v && rdy) begin
            checks++;
            if (d !== exp_d[got] || l !== exp_l[got]) begin
              errors++;
              $display("FAIL rand_word%0d got d=%h l=%0d, required d=%h l=%0d", got, d, l, exp_d[got], exp_l[got]);
            end
            got++;
          end
        end
        down_ready = 1'b0;
        if (got < nexp) begin
          checks++; errors++;
          $display("FAIL rand_timeout got %0d words, required %0d", got, nexp);
        end
      end
    join
  endtask

  initial begin
    test_reset();
    test_full_and_hold();
    test_xor_short();
    test_op_latch();
    test_last_at_full();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
